debug_display: RTL

//  Board-level debug display for the CPU top. Captures a DATA_W-bit word, mirrors its low 16 bits on led.

---
 rtl/debug_display.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/debug_display.sv
// Board debug display: captures a word, mirrors it on the LEDs and scans one page of it
// as hex on a multiplexed seven-segment display; debounced buttons select page and freeze.
module debug_display #(
  parameter int DATA_W          = 32,
  parameter int NUM_DIGITS      = 4,
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  localparam int PAGES          = DATA_W / (4 * NUM_DIGITS),
  localparam int PAGE_W         = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     data,
  input  logic                  data_valid,
  input  logic                  btn_page,
  input  logic                  btn_freeze,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [15:0]           led,
  output logic [PAGE_W-1:0]     page,
  output logic                  frozen
);

  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int SEL_W = (PAGES * NUM_DIGITS > 1) ? $clog2(PAGES * NUM_DIGITS) : 1;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      4'hF: hex7 = 7'h0E;
      default: hex7 = 7'h7F;
    endcase
  endfunction

  logic [DATA_W-1:0]     captured_r;
  logic [15:0]           led_r;
  logic [PAGE_W-1:0]     page_r;
  logic                  frozen_r;
  logic [PRE_W-1:0]      prescaler_r;
  logic [DIG_W-1:0]      digit_r;
  logic [NUM_DIGITS-1:0] an_r;
  logic [6:0]            seg_r;
  logic [1:0]            sync1_r, sync2_r, fill_r, stable_r, armed_r, pulse_r;
  logic [1:0][CNT_W-1:0] cnt_r;
  logic [1:0]            btn_s;
  logic [SEL_W-1:0]      sel_s;
  logic [DATA_W-1:0]     shifted_s;
  logic [3:0]            nibble_s;

  assign btn_s = {btn_freeze, btn_page};

  // Nibble currently addressed by the page and the digit being lit.
  always_comb begin
    sel_s     = SEL_W'(page_r) * SEL_W'(NUM_DIGITS) + SEL_W'(digit_r);
    shifted_s = captured_r >> {sel_s, 2'b00};
    nibble_s  = shifted_s[3:0];
  end

  // Button synchronisers and debouncers; a button must be seen released after reset
  // (armed) before its press can pulse, so a button held through reset stays silent.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r  <= 2'b00;
      sync2_r  <= 2'b00;
      fill_r   <= 2'b00;
      stable_r <= 2'b00;
      armed_r  <= 2'b00;
      pulse_r  <= 2'b00;
      cnt_r    <= {2{{CNT_W{1'b0}}}};
    end else begin
      sync1_r <= btn_s;
      sync2_r <= sync1_r;
      fill_r  <= {fill_r[0], 1'b1};
      for (int i = 0; i < 2; i++) begin
        pulse_r[i] <= 1'b0;
        if (sync2_r[i] == stable_r[i]) begin
          cnt_r[i] <= {CNT_W{1'b0}};
          if (fill_r[1] && !sync2_r[i]) begin
            armed_r[i] <= 1'b1;
          end else begin
            armed_r[i] <= armed_r[i];
          end
        end else if (cnt_r[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_r[i] <= sync2_r[i];
          cnt_r[i]    <= {CNT_W{1'b0}};
          pulse_r[i]  <= sync2_r[i] & armed_r[i];
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  // Capture, LED mirror, page selection and freeze toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      captured_r <= {DATA_W{1'b0}};
      led_r      <= 16'h0000;
      page_r     <= {PAGE_W{1'b0}};
      frozen_r   <= 1'b0;
    end else begin
      if (data_valid && !frozen_r) begin
        captured_r <= data;
      end else begin
        captured_r <= captured_r;
      end
      led_r <= 16'(captured_r);
      if (pulse_r[0]) begin
        page_r <= (page_r == PAGE_W'(PAGES - 1)) ? {PAGE_W{1'b0}} : page_r + PAGE_W'(1);
      end else begin
        page_r <= page_r;
      end
      if (pulse_r[1]) begin
        frozen_r <= ~frozen_r;
      end else begin
        frozen_r <= frozen_r;
      end
    end
  end

  // Digit scan: an and seg are loaded together from the same digit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_r <= {PRE_W{1'b0}};
      digit_r     <= {DIG_W{1'b0}};
      an_r        <= {NUM_DIGITS{1'b1}};
      seg_r       <= 7'h7F;
    end else begin
      if (prescaler_r == PRE_W'(SCAN_DIV - 1)) begin
        prescaler_r <= {PRE_W{1'b0}};
        digit_r     <= (digit_r == DIG_W'(NUM_DIGITS - 1)) ? {DIG_W{1'b0}} : digit_r + DIG_W'(1);
      end else begin
        prescaler_r <= prescaler_r + PRE_W'(1);
      end
      an_r  <= ~(NUM_DIGITS'(1) << digit_r);
      seg_r <= hex7(nibble_s);
    end
  end

  assign seg    = seg_r;
  assign an     = an_r;
  assign led    = led_r;
  assign page   = page_r;
  assign frozen = frozen_r;

endmodule
